// File: rtl/simmem_resp_release_bank_if.sv
// Handshake bundle between the response release bank and its environment.
// Latency: none, wires only.
// Backpressure: carries rsv/rsp/out valid-ready pairs; the bank is the slave side.
interface simmem_resp_release_bank_if #(
  parameter int Capacity = 16,
  parameter int RspWidth = 8
);
  localparam int IidWidth = $clog2(Capacity);

  logic                rsv_valid_i;
  logic                rsv_ready_o;
  logic [IidWidth-1:0] rsv_iid_o;
  logic                rsp_valid_i;
  logic                rsp_ready_o;
  logic [RspWidth-1:0] rsp_data_i;
  logic [Capacity-1:0] release_en_i;
  logic [Capacity-1:0] released_addr_onehot_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [RspWidth-1:0] out_data_o;
  logic [IidWidth-1:0] out_iid_o;

  modport master (
    output rsv_valid_i, rsp_valid_i, rsp_data_i, release_en_i, out_ready_i,
    input  rsv_ready_o, rsv_iid_o, rsp_ready_o, released_addr_onehot_o,
           out_valid_o, out_data_o, out_iid_o
  );

  modport slave (
    input  rsv_valid_i, rsp_valid_i, rsp_data_i, release_en_i, out_ready_i,
    output rsv_ready_o, rsv_iid_o, rsp_ready_o, released_addr_onehot_o,
           out_valid_o, out_data_o, out_iid_o
  );
endinterface

// File: rtl/simmem_resp_release_bank.sv
// Allocates iids, stores in-order responses under them, releases them when the calculator enables them.
// Latency: eligible slot -> out_valid_o next cycle; released pulse one cycle after the out handshake.
// Backpressure: out_ready_i low holds the output register; rsv/rsp stall while no FREE/RESERVED slot.
module simmem_resp_release_bank #(
  parameter int Capacity = 16,
  parameter int RspWidth = 8
) (
  input logic clk_i,
  input logic rst_i,
  simmem_resp_release_bank_if.slave bus
);
  localparam int IidWidth = $clog2(Capacity);

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_RESERVED = 2'd1,
    SLOT_FILLED   = 2'd2,
    SLOT_OUT      = 2'd3
  } slot_state_e;

  slot_state_e         state_q [Capacity];
  slot_state_e         state_d [Capacity];
  logic [RspWidth-1:0] data_q  [Capacity];
  logic [IidWidth-1:0] fifo_q  [Capacity];
  logic [IidWidth:0]   wr_ptr_q;
  logic [IidWidth:0]   rd_ptr_q;

  logic                out_valid_q;
  logic [RspWidth-1:0] out_data_q;
  logic [IidWidth-1:0] out_iid_q;
  logic [Capacity-1:0] released_q;

  logic [Capacity-1:0] free_vec;
  logic [Capacity-1:0] elig_vec;
  logic [Capacity-1:0] out_vec;
  logic [IidWidth-1:0] rsv_iid;
  logic [IidWidth-1:0] elig_iid;
  logic [IidWidth-1:0] head_iid;
  logic                fifo_empty;
  logic                rsv_hs;
  logic                rsp_hs;
  logic                out_hs;
  logic                load;

  // Classify slots; a slot whose release pulse is still on the wire is not yet offered for reservation.
  always_comb begin
    free_vec = '0;
    elig_vec = '0;
    out_vec  = '0;
    for (int i = 0; i < Capacity; i++) begin
      free_vec[i] = (state_q[i] == SLOT_FREE) && !released_q[i];
      elig_vec[i] = (state_q[i] == SLOT_FILLED) && bus.release_en_i[i];
      out_vec[i]  = (state_q[i] == SLOT_OUT);
    end
  end

  // Lowest-index FREE slot for reservation and lowest-index eligible slot for release.
  always_comb begin
    rsv_iid  = '0;
    elig_iid = '0;
    for (int i = Capacity - 1; i >= 0; i--) begin
      if (free_vec[i]) rsv_iid = IidWidth'(i);
      if (elig_vec[i]) elig_iid = IidWidth'(i);
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head_iid   = fifo_q[rd_ptr_q[IidWidth-1:0]];

  assign rsv_hs = bus.rsv_valid_i && bus.rsv_ready_o;
  assign rsp_hs = bus.rsp_valid_i && bus.rsp_ready_o;
  assign out_hs = out_valid_q && bus.out_ready_i;
  assign load   = (|elig_vec) && (!out_valid_q || bus.out_ready_i);

  assign bus.rsv_ready_o            = |free_vec;
  assign bus.rsv_iid_o              = rsv_iid;
  assign bus.rsp_ready_o            = !fifo_empty;
  assign bus.out_valid_o            = out_valid_q;
  assign bus.out_data_o             = out_data_q;
  assign bus.out_iid_o              = out_iid_q;
  assign bus.released_addr_onehot_o = released_q;

  // Per-slot next state; the four handshakes always address distinct slots.
  always_comb begin
    for (int i = 0; i < Capacity; i++) state_d[i] = state_q[i];
    if (out_hs) state_d[out_iid_q] = SLOT_FREE;
    if (rsv_hs) state_d[rsv_iid]   = SLOT_RESERVED;
    if (rsp_hs) state_d[head_iid]  = SLOT_FILLED;
    if (load)   state_d[elig_iid]  = SLOT_OUT;
  end

  // Slot state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Capacity; i++) state_q[i] <= SLOT_FREE;
    end else begin
      for (int i = 0; i < Capacity; i++) state_q[i] <= state_d[i];
    end
  end

  // Order FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (rsv_hs) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rsp_hs) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Payload and FIFO storage; contents are only read once qualified by state, so no reset.
  always_ff @(posedge clk_i) begin
    if (rsv_hs) fifo_q[wr_ptr_q[IidWidth-1:0]] <= rsv_iid;
    if (rsp_hs) data_q[head_iid] <= bus.rsp_data_i;
  end

  // Output register and one-cycle release pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_iid_q   <= '0;
      released_q  <= '0;
    end else begin
      released_q <= '0;
      if (out_hs) released_q[out_iid_q] <= 1'b1;
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= data_q[elig_iid];
        out_iid_q   <= elig_iid;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // A fill only ever lands on the reservation waiting at the FIFO head.
  assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_hs |-> (!fifo_empty && state_q[head_iid] == SLOT_RESERVED));
  assert property (@(posedge clk_i) disable iff (rst_i) $countones(out_vec) <= 1);
  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(released_q));
endmodule

// File: tb/tb_simmem_resp_release_bank.sv
// Directed bench for the response release bank with a scoreboard on the output port.
// Latency: checks one-cycle load latency and the release pulse the cycle after a handshake.
// Backpressure: holds out_ready low for several cycles and checks output stability.
module tb_simmem_resp_release_bank;
  logic clk;
  logic rst;

  typedef struct {
    logic [3:0] iid;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  simmem_resp_release_bank_if #(.Capacity(16), .RspWidth(8)) bus ();

  simmem_resp_release_bank #(.Capacity(16), .RspWidth(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [3:0] iid, input logic [7:0] data);
    exp_t e;
    e.iid  = iid;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic reserve(input logic [3:0] exp_iid);
    check("rsv_ready", 32'(bus.rsv_ready_o), 32'd1);
    check($sformatf("rsv_iid_%0d", exp_iid), 32'(bus.rsv_iid_o), 32'(exp_iid));
    bus.rsv_valid_i = 1'b1;
    tick();
    bus.rsv_valid_i = 1'b0;
  endtask

  task automatic fill(input logic [7:0] data);
    check("rsp_ready", 32'(bus.rsp_ready_o), 32'd1);
    bus.rsp_valid_i = 1'b1;
    bus.rsp_data_i  = data;
    tick();
    bus.rsp_valid_i = 1'b0;
  endtask

  // Monitor: scoreboard on out handshakes, release pulse and hold-stability checks.
  logic        pend_vld = 1'b0;
  logic [15:0] pend_mask = '0;
  logic        hold_vld = 1'b0;
  logic [3:0]  hold_iid = '0;
  logic [7:0]  hold_data = '0;

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] one;
    one = 16'd1;
    if (rst) begin
      pend_vld = 1'b0;
      hold_vld = 1'b0;
    end else begin
      if (pend_vld) check("released_pulse", 32'(bus.released_addr_onehot_o), 32'(pend_mask));
      else          check("released_idle", 32'(bus.released_addr_onehot_o), 32'd0);
      pend_vld = 1'b0;
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got iid %0d data 0x%0h, none expected", bus.out_iid_o, bus.out_data_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_out_iid", 32'(bus.out_iid_o), 32'(e.iid));
          check("sb_out_data", 32'(bus.out_data_o), 32'(e.data));
        end
        pend_vld  = 1'b1;
        pend_mask = one << bus.out_iid_o;
        hold_vld  = 1'b0;
      end else if (bus.out_valid_o) begin
        if (hold_vld) begin
          check("hold_iid", 32'(bus.out_iid_o), 32'(hold_iid));
          check("hold_data", 32'(bus.out_data_o), 32'(hold_data));
        end
        hold_vld  = 1'b1;
        hold_iid  = bus.out_iid_o;
        hold_data = bus.out_data_o;
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  initial begin
    rst              = 1'b1;
    bus.rsv_valid_i  = 1'b0;
    bus.rsp_valid_i  = 1'b0;
    bus.rsp_data_i   = '0;
    bus.release_en_i = '0;
    bus.out_ready_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_rsv_ready", 32'(bus.rsv_ready_o), 32'd1);
    check("rst_rsv_iid", 32'(bus.rsv_iid_o), 32'd0);
    check("rst_rsp_ready", 32'(bus.rsp_ready_o), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_released", 32'(bus.released_addr_onehot_o), 32'd0);

    // Reserve three, fill A B C, release iid 1 only
    reserve(4'd0);
    reserve(4'd1);
    reserve(4'd2);
    fill(8'hA1);
    fill(8'hB2);
    fill(8'hC3);
    check("rsp_ready_drained", 32'(bus.rsp_ready_o), 32'd0);
    expect_out(4'd1, 8'hB2);
    bus.release_en_i = 16'h0002;
    check("t1_idle_before", 32'(bus.out_valid_o), 32'd0);
    tick();
    check("t1_out_valid", 32'(bus.out_valid_o), 32'd1);
    check("t1_out_iid", 32'(bus.out_iid_o), 32'd1);
    check("t1_out_data", 32'(bus.out_data_o), 32'hB2);
    bus.out_ready_i = 1'b1;
    tick();
    check("t1_pulse", 32'(bus.released_addr_onehot_o), 32'h0002);
    check("t1_out_drop", 32'(bus.out_valid_o), 32'd0);
    bus.release_en_i = '0;
    tick();
    check("t1_pulse_gone", 32'(bus.released_addr_onehot_o), 32'd0);
    expect_out(4'd0, 8'hA1);
    expect_out(4'd2, 8'hC3);
    bus.release_en_i = 16'h0005;
    repeat (4) tick();
    bus.release_en_i = '0;
    bus.out_ready_i  = 1'b0;
    tick();

    // Fill all sixteen slots, then release iid 5
    for (int i = 0; i < 16; i++) reserve(4'(i));
    check("full_rsv_ready", 32'(bus.rsv_ready_o), 32'd0);
    for (int i = 0; i < 16; i++) fill(8'h10 + 8'(i));
    expect_out(4'd5, 8'h15);
    bus.release_en_i = 16'h0020;
    bus.out_ready_i  = 1'b1;
    tick();
    check("t2_out_iid", 32'(bus.out_iid_o), 32'd5);
    check("t2_rsv_ready_c1", 32'(bus.rsv_ready_o), 32'd0);
    tick();
    check("t2_pulse", 32'(bus.released_addr_onehot_o), 32'h0020);
    check("t2_rsv_ready_pulse", 32'(bus.rsv_ready_o), 32'd0);
    bus.release_en_i = '0;
    bus.out_ready_i  = 1'b0;
    tick();
    check("t2_rsv_ready_after", 32'(bus.rsv_ready_o), 32'd1);
    check("t2_rsv_iid_after", 32'(bus.rsv_iid_o), 32'd5);

    // Enable 2,3,4 together: back-to-back outputs, pulses trail by one
    expect_out(4'd2, 8'h12);
    expect_out(4'd3, 8'h13);
    expect_out(4'd4, 8'h14);
    bus.release_en_i = 16'h001C;
    bus.out_ready_i  = 1'b1;
    tick();
    check("t3_c1_iid", 32'(bus.out_iid_o), 32'd2);
    check("t3_c1_pulse", 32'(bus.released_addr_onehot_o), 32'd0);
    tick();
    check("t3_c2_iid", 32'(bus.out_iid_o), 32'd3);
    check("t3_c2_pulse", 32'(bus.released_addr_onehot_o), 32'h0004);
    tick();
    check("t3_c3_iid", 32'(bus.out_iid_o), 32'd4);
    check("t3_c3_pulse", 32'(bus.released_addr_onehot_o), 32'h0008);
    tick();
    check("t3_c4_valid", 32'(bus.out_valid_o), 32'd0);
    check("t3_c4_pulse", 32'(bus.released_addr_onehot_o), 32'h0010);
    bus.release_en_i = '0;
    bus.out_ready_i  = 1'b0;

    // Backpressure on iid 6 while its enable drops
    expect_out(4'd6, 8'h16);
    bus.release_en_i = 16'h0040;
    tick();
    bus.release_en_i = '0;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(bus.out_valid_o), 32'd1);
      check("t4_hold_iid", 32'(bus.out_iid_o), 32'd6);
      check("t4_hold_data", 32'(bus.out_data_o), 32'h16);
      tick();
    end
    bus.out_ready_i = 1'b1;
    tick();
    check("t4_pulse", 32'(bus.released_addr_onehot_o), 32'h0040);
    bus.out_ready_i = 1'b0;

    // Same cycle: reserve 3, fill 2, hand out 0
    reserve(4'd2);
    expect_out(4'd0, 8'h10);
    bus.release_en_i = 16'h0001;
    tick();
    bus.release_en_i = '0;
    check("t5_out_iid", 32'(bus.out_iid_o), 32'd0);
    check("t5_rsv_iid", 32'(bus.rsv_iid_o), 32'd3);
    check("t5_rsp_ready", 32'(bus.rsp_ready_o), 32'd1);
    bus.rsv_valid_i = 1'b1;
    bus.rsp_valid_i = 1'b1;
    bus.rsp_data_i  = 8'h22;
    bus.out_ready_i = 1'b1;
    tick();
    bus.rsv_valid_i = 1'b0;
    bus.rsp_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    check("t5_pulse", 32'(bus.released_addr_onehot_o), 32'h0001);
    check("t5_rsp_ready_next", 32'(bus.rsp_ready_o), 32'd1);
    check("t5_rsv_iid_next", 32'(bus.rsv_iid_o), 32'd4);
    check("t5_out_valid", 32'(bus.out_valid_o), 32'd0);
    fill(8'h33);
    check("t5_fifo_empty", 32'(bus.rsp_ready_o), 32'd0);
    check("t5_rsv_iid_freed", 32'(bus.rsv_iid_o), 32'd0);
    expect_out(4'd2, 8'h22);
    expect_out(4'd3, 8'h33);
    bus.release_en_i = 16'h000C;
    bus.out_ready_i  = 1'b1;
    repeat (4) tick();
    bus.release_en_i = '0;
    bus.out_ready_i  = 1'b0;
    tick();

    // Asynchronous reset mid-operation with the output register loaded
    bus.release_en_i = 16'h0002;
    tick();
    check("t6_out_valid_pre", 32'(bus.out_valid_o), 32'd1);
    check("t6_out_iid_pre", 32'(bus.out_iid_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("t6_out_data", 32'(bus.out_data_o), 32'd0);
    check("t6_out_iid", 32'(bus.out_iid_o), 32'd0);
    check("t6_released", 32'(bus.released_addr_onehot_o), 32'd0);
    check("t6_rsv_ready", 32'(bus.rsv_ready_o), 32'd1);
    check("t6_rsv_iid", 32'(bus.rsv_iid_o), 32'd0);
    check("t6_rsp_ready", 32'(bus.rsp_ready_o), 32'd0);
    bus.release_en_i = '0;
    tick();
    tick();
    rst = 1'b0;
    reserve(4'd0);
    fill(8'h5A);
    expect_out(4'd0, 8'h5A);
    bus.release_en_i = 16'h0001;
    bus.out_ready_i  = 1'b1;
    repeat (3) tick();
    bus.release_en_i = '0;
    bus.out_ready_i  = 1'b0;
    repeat (2) tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
